// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART transmitter and receiver.
// The state encoding is common to both ends of the link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int CLK_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF   = 8;

  // Clocks from the first start-bit edge seen by the synchronizer to the stop-bit decision.
  function automatic int frame_latency(input int clk_per_bit, input int data_bits);
    return 2 + clk_per_bit / 2 + (data_bits + 1) * clk_per_bit;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// RESET_VAL sets the level both flops hold while reset is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery, LSB first,
// one-cycle valid or frame_err pulse per received frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     clk_count_q, clk_count_d;
  logic [BIT_W-1:0]     bit_index_q, bit_index_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // Idle line is high, so the synchronizer resets to 1 to avoid a phantom start bit.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d     = START;
          clk_count_d = '0;
        end
      end

      START: begin
        if (clk_count_q == HALF_LAST) begin
          clk_count_d = '0;
          if (!rx_s) begin
            state_d     = DATA;
            bit_index_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_count_d = clk_count_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_count_q == BIT_LAST) begin
          clk_count_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_index_q == BIT_W'(i)) shift_d[i] = rx_s;
          end
          bit_index_d = bit_index_q + BIT_W'(1);
          if (bit_index_q == LAST_BIT) state_d = STOP;
        end else begin
          clk_count_d = clk_count_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_count_q == BIT_LAST) begin
          // Decide at mid stop bit so a back-to-back start bit is not missed.
          clk_count_d = '0;
          bit_index_d = '0;
          state_d     = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses,
// a negedge monitor pops and checks kind, data and arrival cycle.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int NBITS   = 8;
  localparam int LAT     = 2 + CPB / 2 + (NBITS + 1) * CPB;   // 154
  localparam int BRK_PER = CPB / 2 + (NBITS + 1) * CPB + 1;   // 153

  logic             clk;
  logic             rst;
  logic             rx;
  logic [NBITS-1:0] data_out;
  logic             valid;
  logic             frame_err;
  logic             busy;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;
  logic [7:0]  last_data;
  bit          prev_pulse;

  uart_rx #(
    .CLK_PER_BIT (CPB),
    .DATA_BITS   (NBITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one frame; the first posedge after rx falls is E0.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int gap,
                             output int unsigned e0);
    @(negedge clk);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < NBITS; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_bit, input int gap);
    exp_t        e;
    int unsigned e0;
    fork
      begin
        @(negedge clk);
        e.is_err = !stop_bit;
        e.data   = stop_bit ? d : last_data;
        e.cyc    = cyc + 1 + LAT;
        sb.push_back(e);
        if (stop_bit) last_data = d;
      end
    join
    // The push above used the same negedge the driver starts on.
    drive_frame_from_now(d, stop_bit, gap);
  endtask

  task automatic drive_frame_from_now(input logic [7:0] d, input logic stop_bit, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < NBITS; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid || frame_err) begin
        chk("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
        chk("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data_out=0x%0h, expected none (cycle %0d)",
                   valid, frame_err, data_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
          chk("data_out", {24'd0, data_out}, {24'd0, e.data});
          chk("pulse_cycle", cyc, e.cyc);
          chk("busy_falls_with_pulse", {31'd0, busy}, 32'd0);
        end
      end
      prev_pulse <= valid || frame_err;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  initial begin
    int unsigned e0;
    exp_t        e;
    checks    = 0;
    errors    = 0;
    last_data = 8'h00;
    rst       = 1'b1;
    rx        = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data_out", {24'd0, data_out}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single 0xA5 frame, busy sampled after entering START
    fork
      send(8'hA5, 1'b1, 2);
      begin
        repeat (4) @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (LAT - 4) @(negedge clk);
        chk("busy_before_valid", {31'd0, busy}, 32'd1);
      end
    join

    // 2: back-to-back 0x00, 0xFF
    send(8'h00, 1'b1, 1);
    send(8'hFF, 1'b1, 4);

    // 3: 5-cycle low glitch is a false start
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    chk("glitch_data_kept", {24'd0, data_out}, 32'h0000_00FF);

    // 4: 0x3C with stop bit low
    send(8'h3C, 1'b0, 30);
    chk("ferr_busy_idle", {31'd0, busy}, 32'd0);

    // 5: reset during data bit 3 of 0x5A, then a clean 0x3C
    begin
      logic [7:0] d;
      d = 8'h5A;
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        rx = d[i];
        repeat (CPB) @(negedge clk);
      end
      rx = d[3];
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midframe_rst_data_out", {24'd0, data_out}, 32'd0);
      chk("midframe_rst_valid", {31'd0, valid}, 32'd0);
      chk("midframe_rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("midframe_rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rx  = 1'b1;
      rst = 1'b0;
      last_data = 8'h00;
      repeat (20) @(negedge clk);
    end
    send(8'h3C, 1'b1, 4);

    // 6: break for three frame periods
    @(negedge clk);
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.is_err = 1'b1;
      e.data   = last_data;
      e.cyc    = e0 + LAT + k * BRK_PER;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (3 * BRK_PER + 7) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("break_busy_idle", {31'd0, busy}, 32'd0);

    begin
      int budget;
      budget = 400;
      while (sb.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that sits directly downstream of the team's uart_tx; its `rx` input connects to uart_tx `tx`, in loopback or across the link.
- Oversamples the serial line at CLK_PER_BIT clocks per bit.
- Validates the start bit, recovers DATA_BITS bits LSB-first and checks the stop bit.
- Presents each byte with a one-cycle valid pulse, or flags a framing error.

Parameters:
- CLK_PER_BIT, 16, clocks per serial bit; must be even and at least 4; must match uart_tx.
- DATA_BITS, 8, data bits per frame; 1 to 8.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, asynchronous to clk; idles high.
- data_out  output  DATA_BITS  last correctly framed byte.
- valid  output  1  one-cycle pulse: data_out updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is being received.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: data_out=0, valid=0, frame_err=0, busy=0, state=IDLE, counters=0, shift register=0, both synchronizer flops=1. Reset applied mid-frame aborts the frame immediately; no pulse is emitted.
- Synchronizer: rx passes through a 2-flop synchronizer. All FSM decisions use the second flop's output (rx_s).
- Counter: clk_count is $clog2(CLK_PER_BIT) bits wide. bit_index is wide enough to count to DATA_BITS.
- IDLE:
  - busy=0.
  - rx_s==0 → START, clk_count=0.
- START:
  - busy=1.
  - Count until clk_count==CLK_PER_BIT/2-1; on the next edge evaluate rx_s (mid start bit).
  - rx_s==0 → DATA, clk_count=0, bit_index=0.
  - rx_s==1 → false start → IDLE; no pulses.
- DATA:
  - busy=1.
  - Count until clk_count==CLK_PER_BIT-1; on the next edge sample rx_s into shift[bit_index] (LSB first) and reset clk_count.
  - After DATA_BITS samples → STOP.
- STOP:
  - busy=1.
  - Same CLK_PER_BIT count, then sample rx_s.
  - 1 → data_out<=shift, valid=1 for exactly one cycle.
  - 0 → frame_err=1 for one cycle; data_out unchanged.
  - Either case → IDLE on the same edge. The receiver does not wait out the second half of the stop bit, so back-to-back frames from uart_tx (stop + cleanup + one idle cycle) are accepted.
- Latency: let E0 be the first edge at which synchronizer flop 1 captures 0. Then:
  - START-bit sample occurs at E0+2+CLK_PER_BIT/2.
  - Data bit k is sampled at E0+2+CLK_PER_BIT/2+(k+1)*CLK_PER_BIT.
  - valid or frame_err is registered at E0+2+CLK_PER_BIT/2+(DATA_BITS+1)*CLK_PER_BIT, which is E0+154 with the defaults.
- Boundary conditions:
  - valid and frame_err are never high together, and never high for two consecutive cycles.
  - A line held low (break) produces one frame_err per frame period. The receiver re-enters START on each IDLE cycle that sees rx_s low.
  - A low glitch shorter than CLK_PER_BIT/2-1 synchronized cycles is rejected as a false start.
  - busy falls on the same edge that valid, frame_err, or the false-start return is registered.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE=0, START=1, DATA=2, STOP=3 (reused by uart_tx);
  - default CLK_PER_BIT=16.
- One sub-module, sync_2ff: generic two-flop synchronizer with a RESET_VAL parameter and asynchronous active-high reset. Instantiated here with RESET_VAL=1.

Test Plan:
1. Loopback uart_tx→uart_rx, send 0xA5 → exactly one valid pulse with data_out=0xA5 at the computed latency edge; frame_err stays 0; busy high from E0+3 until the valid edge.
2. Back-to-back 0x00 then 0xFF, with start asserted as soon as uart_tx busy drops → two valid pulses with data_out 0x00 then 0xFF; no frame_err.
3. rx driven low for 5 cycles, then high → busy pulses then returns to 0; no valid, no frame_err; data_out unchanged.
4. Hand-driven frame 0x3C with the stop bit held low → one frame_err pulse at the stop-sample edge; valid=0; data_out keeps its previous value (0xFF after scenario 2).
5. rst asserted during data bit 3 of a 0x5A frame → all outputs 0 in that cycle; after release, a full 0x3C frame is received correctly (valid, data_out=0x3C).
6. rx held low for 3 frame periods → exactly 3 frame_err pulses, spaced CLK_PER_BIT/2+(DATA_BITS+1)*CLK_PER_BIT+1 cycles apart; no valid.
